// File: rtl/ysyx_22050710_mem_stage_oq_pkg.sv
// Shared widths, bus layouts and the load-op encoding for the memory stage
// and its outstanding queue.
package ysyx_22050710_mem_stage_oq_pkg;

  localparam int WORD_WD      = 64;
  localparam int PC_WD        = 64;
  localparam int INST_WD      = 32;
  localparam int GPR_ADDR_WD  = 5;
  localparam int CSR_ADDR_WD  = 12;
  localparam int SRAM_DATA_WD = 64;
  localparam int DEBUG_BUS_WD = 2 * PC_WD + INST_WD + 1 + WORD_WD;

  localparam int ES_TO_MS_BUS_WD = GPR_ADDR_WD + CSR_ADDR_WD + 8 + 3 * WORD_WD;
  localparam int MS_TO_WS_BUS_WD = 2 + GPR_ADDR_WD + CSR_ADDR_WD + 2 * WORD_WD;
  localparam int BYPASS_BUS_WD   = GPR_ADDR_WD + CSR_ADDR_WD + 2 * WORD_WD;

  // Load width/sign encoding, identical to the RISC-V load funct3 field.
  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LD  = 3'b011,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101,
    MEM_LWU = 3'b110
  } mem_op_e;

  typedef struct packed {
    logic [GPR_ADDR_WD-1:0] rd;
    logic [CSR_ADDR_WD-1:0] csr;
    logic                   gpr_wen;
    logic                   csr_wen;
    logic                   mem_ren;
    logic                   mem_wen;
    logic [2:0]             mem_op;
    logic                   csr_inst_sel;
    logic [WORD_WD-1:0]     csrrdata;
    logic [WORD_WD-1:0]     alu_result;
    logic [WORD_WD-1:0]     csr_result;
  } es_to_ms_t;

  typedef struct packed {
    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] rd;
    logic [WORD_WD-1:0]     gpr_result;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr;
    logic [WORD_WD-1:0]     csr_result;
  } ms_to_ws_t;

  typedef struct packed {
    logic [GPR_ADDR_WD-1:0] rd;
    logic [WORD_WD-1:0]     result;
    logic [CSR_ADDR_WD-1:0] csr;
    logic [WORD_WD-1:0]     csr_result;
  } bypass_t;

endpackage

// File: rtl/ysyx_22050710_mem_stage_oq_lsu_load.sv
// Load data extraction: aligns the addressed lane of a 64-bit read word and
// sign/zero extends it according to the load op.
module ysyx_22050710_lsu_load
  import ysyx_22050710_mem_stage_oq_pkg::*;
(
  input  logic [2:0]              addr_i,
  input  logic [SRAM_DATA_WD-1:0] rdata_i,
  input  logic [2:0]              mem_op_i,
  output logic [WORD_WD-1:0]      data_o
);

  logic [SRAM_DATA_WD-1:0] shifted;

  assign shifted = rdata_i >> {addr_i, 3'b000};

  // NOTE: every path assigns data_o (default arm included), so no latch is inferred.
  always_comb begin
    case (mem_op_e'(mem_op_i))
      MEM_LB:  data_o = {{56{shifted[7]}},  shifted[7:0]};
      MEM_LH:  data_o = {{48{shifted[15]}}, shifted[15:0]};
      MEM_LW:  data_o = {{32{shifted[31]}}, shifted[31:0]};
      MEM_LBU: data_o = {56'b0, shifted[7:0]};
      MEM_LHU: data_o = {48'b0, shifted[15:0]};
      MEM_LWU: data_o = {32'b0, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_mem_stage_oq.sv
// Memory stage with an in-order outstanding queue; retires to WB in program order.
// Optional: YSYX_22050710_MS_DATA_OK_FWD_EN forwards data_ok/rdata straight to a waiting head.
module ysyx_22050710_mem_stage_oq
  import ysyx_22050710_mem_stage_oq_pkg::*;
#(
  parameter int OQ_DEPTH = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_ws_allowin,
  output logic                                 o_ms_allowin,
  input  logic                                 i_es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]           i_es_to_ms_bus,
  output logic                                 o_ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]           o_ms_to_ws_bus,
  input  logic                                 i_data_sram_data_ok,
  input  logic [SRAM_DATA_WD-1:0]              i_data_sram_rdata,
  output logic [BYPASS_BUS_WD-1:0]             o_ms_to_ds_bypass_bus,
  output logic [OQ_DEPTH*(1+GPR_ADDR_WD)-1:0]  o_ms_hazard_bus,
  output logic [$clog2(OQ_DEPTH):0]            o_ms_oq_cnt,
  input  logic [DEBUG_BUS_WD-1:0]              i_debug_es_to_ms_bus,
  output logic [DEBUG_BUS_WD-1:0]              o_debug_ms_to_ws_bus
);

  localparam int PTR_WD = $clog2(OQ_DEPTH);
  localparam int CNT_WD = PTR_WD + 1;

  typedef logic [PTR_WD-1:0] ptr_t;
  typedef logic [CNT_WD-1:0] cnt_t;

  ptr_t                    head_q, tail_q;
  cnt_t                    cnt_q, cnt_d;
  logic [OQ_DEPTH-1:0]     valid_q, valid_d, done_q, done_d;
  es_to_ms_t               ent_q   [OQ_DEPTH];
  logic [SRAM_DATA_WD-1:0] rdata_q [OQ_DEPTH];
  logic [DEBUG_BUS_WD-1:0] dbg_q   [OQ_DEPTH];

  es_to_ms_t               es_in, head_ent, yng_ent;
  ptr_t                    yng_idx, resp_idx, scan_idx;
  logic                    resp_found, resp_hit, head_fwd, push, pop;
  logic [SRAM_DATA_WD-1:0] head_rdata;
  logic [WORD_WD-1:0]      head_load, yng_load, yng_result;
  logic                    byp_ok;
  ms_to_ws_t               ws_out;
  bypass_t                 byp_out;

  assign es_in    = es_to_ms_t'(i_es_to_ms_bus);
  assign head_ent = ent_q[head_q];
  assign yng_idx  = tail_q - ptr_t'(1);
  assign yng_ent  = ent_q[yng_idx];

`ifdef YSYX_22050710_MS_DATA_OK_FWD_EN
  // An undone mem head can retire in the very cycle its response arrives.
  assign head_fwd   = valid_q[head_q] && !done_q[head_q] && i_data_sram_data_ok
                      && (head_ent.mem_ren || head_ent.mem_wen);
  assign head_rdata = done_q[head_q] ? rdata_q[head_q] : i_data_sram_rdata;
`else
  assign head_fwd   = 1'b0;
  assign head_rdata = rdata_q[head_q];
`endif

  assign o_ms_to_ws_valid = valid_q[head_q] && (done_q[head_q] || head_fwd);
  assign pop              = o_ms_to_ws_valid && i_ws_allowin;
  assign o_ms_allowin     = (cnt_q < cnt_t'(OQ_DEPTH)) || pop;
  assign push             = i_es_to_ms_valid && o_ms_allowin;
  assign o_ms_oq_cnt      = cnt_q;

  // Responses return in request order, so the oldest undone mem entry owns data_ok.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = head_q;
    scan_idx   = head_q;
    for (int k = 0; k < OQ_DEPTH; k++) begin
      scan_idx = head_q + ptr_t'(k);
      if (!resp_found && valid_q[scan_idx] && !done_q[scan_idx]
          && (ent_q[scan_idx].mem_ren || ent_q[scan_idx].mem_wen)) begin
        resp_found = 1'b1;
        resp_idx   = scan_idx;
      end
    end
  end

  assign resp_hit = i_data_sram_data_ok && resp_found;

  // Pop, then response, then push: a full-queue push reuses the slot just popped.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (pop)      valid_d[head_q]  = 1'b0;
    if (resp_hit) done_d[resp_idx] = 1'b1;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = !(es_in.mem_ren || es_in.mem_wen);
    end
    cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= pop  ? head_q + ptr_t'(1) : head_q;
      tail_q  <= push ? tail_q + ptr_t'(1) : tail_q;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // NOTE: payload rows are not reset; valid_q qualifies every use of them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      ent_q[tail_q] <= es_in;
      dbg_q[tail_q] <= i_debug_es_to_ms_bus;
    end
    if (resp_hit) rdata_q[resp_idx] <= i_data_sram_rdata;
  end

  ysyx_22050710_lsu_load u_head_load (
    .addr_i   (head_ent.alu_result[2:0]),
    .rdata_i  (head_rdata),
    .mem_op_i (head_ent.mem_op),
    .data_o   (head_load)
  );

  ysyx_22050710_lsu_load u_yng_load (
    .addr_i   (yng_ent.alu_result[2:0]),
    .rdata_i  (rdata_q[yng_idx]),
    .mem_op_i (yng_ent.mem_op),
    .data_o   (yng_load)
  );

  always_comb begin
    ws_out = '0;
    if (valid_q[head_q]) begin
      ws_out.gpr_wen    = head_ent.gpr_wen;
      ws_out.rd         = head_ent.rd;
      ws_out.gpr_result = head_ent.mem_ren ? head_load
                        : (head_ent.csr_inst_sel ? head_ent.csrrdata : head_ent.alu_result);
      ws_out.csr_wen    = head_ent.csr_wen;
      ws_out.csr        = head_ent.csr;
      ws_out.csr_result = head_ent.csr_result;
    end
  end

  assign o_ms_to_ws_bus       = ws_out;
  assign o_debug_ms_to_ws_bus = valid_q[head_q] ? dbg_q[head_q] : '0;

  // Bypass only from the youngest entry, and only once its value is final.
  assign yng_result = yng_ent.mem_ren ? yng_load
                    : (yng_ent.csr_inst_sel ? yng_ent.csrrdata : yng_ent.alu_result);
  assign byp_ok     = valid_q[yng_idx] && !yng_ent.mem_wen
                      && !(yng_ent.mem_ren && !done_q[yng_idx]);

  always_comb begin
    byp_out = '0;
    if (byp_ok && yng_ent.gpr_wen) begin
      byp_out.rd     = yng_ent.rd;
      byp_out.result = yng_result;
    end
    if (byp_ok && yng_ent.csr_wen) begin
      byp_out.csr        = yng_ent.csr;
      byp_out.csr_result = yng_ent.csr_result;
    end
  end

  assign o_ms_to_ds_bypass_bus = byp_out;

  for (genvar i = 0; i < OQ_DEPTH; i++) begin : g_hazard
    logic is_yng;
    assign is_yng = (ptr_t'(i) == yng_idx);
    assign o_ms_hazard_bus[i*(1+GPR_ADDR_WD)+GPR_ADDR_WD] =
      valid_q[i] && ent_q[i].gpr_wen && (!done_q[i] || !is_yng);
    assign o_ms_hazard_bus[i*(1+GPR_ADDR_WD) +: GPR_ADDR_WD] =
      valid_q[i] ? ent_q[i].rd : '0;
  end

endmodule

// File: tb/tb_ysyx_22050710_mem_stage_oq.sv
// Self-checking bench for the memory-stage outstanding queue (OQ_DEPTH=2),
// scoreboard of expected WB retirements; honours YSYX_22050710_MS_DATA_OK_FWD_EN.
module tb_ysyx_22050710_mem_stage_oq;
  import ysyx_22050710_mem_stage_oq_pkg::*;

  localparam int DEPTH = 2;
`ifdef YSYX_22050710_MS_DATA_OK_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct packed {
    ms_to_ws_t               bus;
    logic [DEBUG_BUS_WD-1:0] dbg;
  } exp_t;

  logic                          clk, rst;
  logic                          ws_allowin, ms_allowin;
  logic                          es_valid;
  logic [ES_TO_MS_BUS_WD-1:0]    es_bus;
  logic                          ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0]    ws_bus;
  logic                          dok;
  logic [SRAM_DATA_WD-1:0]       rdata;
  logic [BYPASS_BUS_WD-1:0]      byp_bus;
  logic [DEPTH*(1+GPR_ADDR_WD)-1:0] hz_bus;
  logic [$clog2(DEPTH):0]        cnt;
  logic [DEBUG_BUS_WD-1:0]       dbg_in, dbg_out;

  exp_t exp_q[$];
  exp_t mon_x;
  int   n_total = 0;
  int   n_bad   = 0;

  ysyx_22050710_mem_stage_oq #(.OQ_DEPTH(DEPTH)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_ws_allowin          (ws_allowin),
    .o_ms_allowin          (ms_allowin),
    .i_es_to_ms_valid      (es_valid),
    .i_es_to_ms_bus        (es_bus),
    .o_ms_to_ws_valid      (ws_valid),
    .o_ms_to_ws_bus        (ws_bus),
    .i_data_sram_data_ok   (dok),
    .i_data_sram_rdata     (rdata),
    .o_ms_to_ds_bypass_bus (byp_bus),
    .o_ms_hazard_bus       (hz_bus),
    .o_ms_oq_cnt           (cnt),
    .i_debug_es_to_ms_bus  (dbg_in),
    .o_debug_ms_to_ws_bus  (dbg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [2:0] a, input logic [63:0] d,
                                             input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    int          sh;
    sh = int'(a) * 8;
    b  = d[sh +: 8];
    h  = d[(int'(a) / 2) * 16 +: 16];
    w  = d[(int'(a) / 4) * 32 +: 32];
    case (op)
      3'd0:    return {{56{b[7]}}, b};
      3'd1:    return {{48{h[15]}}, h};
      3'd2:    return {{32{w[31]}}, w};
      3'd4:    return {56'b0, b};
      3'd5:    return {48'b0, h};
      3'd6:    return {32'b0, w};
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry; the expected retirement is queued when it is accepted.
  task automatic alloc(input logic [4:0] rd, input logic gpr_wen, input logic ren,
                       input logic wen, input logic [2:0] op, input logic sel,
                       input logic [63:0] alu, input logic [63:0] planned);
    es_to_ms_t    e;
    exp_t         x;
    logic [255:0] rnd;
    for (int i = 0; i < 8; i++) rnd[i*32 +: 32] = $urandom();
    e              = '0;
    e.rd           = rd;
    e.csr          = 12'h300 + 12'(rd);
    e.gpr_wen      = gpr_wen;
    e.csr_wen      = sel;
    e.mem_ren      = ren;
    e.mem_wen      = wen;
    e.mem_op       = op;
    e.csr_inst_sel = sel;
    e.csrrdata     = 64'hC5C5_0000_0000_0000 | 64'(rd);
    e.alu_result   = alu;
    e.csr_result   = alu ^ 64'hA5A5;
    es_valid = 1'b1;
    es_bus   = e;
    dbg_in   = rnd[DEBUG_BUS_WD-1:0];
    #1;
    check("alloc_accept", ms_allowin, 1);
    x.bus.gpr_wen    = gpr_wen;
    x.bus.rd         = rd;
    x.bus.gpr_result = ren ? model_load(alu[2:0], planned, op) : (sel ? e.csrrdata : alu);
    x.bus.csr_wen    = sel;
    x.bus.csr        = e.csr;
    x.bus.csr_result = e.csr_result;
    x.dbg            = rnd[DEBUG_BUS_WD-1:0];
    exp_q.push_back(x);
    step();
    es_valid = 1'b0;
  endtask

  task automatic resp(input logic [63:0] d);
    dok   = 1'b1;
    rdata = d;
    step();
    dok = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (cnt != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_cnt", cnt, 0);
  endtask

  // Retirement monitor: compares every WB handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && ws_valid && ws_allowin) begin
      check("retire_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_x = exp_q.pop_front();
        check("retire_bus", ws_bus, mon_x.bus);
        check("retire_dbg", dbg_out, mon_x.dbg);
      end
    end
  end

  initial begin
    bypass_t b;
    logic [63:0] r1, r2;
    rst = 1'b1; ws_allowin = 1'b0; es_valid = 1'b0; es_bus = '0;
    dok = 1'b0; rdata = '0; dbg_in = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;

    // 1: reset state
    check("rst_allowin", ms_allowin, 1);
    check("rst_valid",   ws_valid, 0);
    check("rst_cnt",     cnt, 0);
    check("rst_ws_bus",  ws_bus, 0);
    check("rst_bypass",  byp_bus, 0);
    check("rst_hazard",  hz_bus, 0);
    check("rst_debug",   dbg_out, 0);

    // 2: non-mem add retires the next cycle
    ws_allowin = 1'b1;
    alloc(5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h5, 64'h0);
    check("add_cnt", cnt, 1);
    check("add_valid", ws_valid, 1);
    b = '0; b.rd = 5'd3; b.result = 64'h5;
    check("add_bypass", byp_bus, b);
    step();
    check("add_cnt_after", cnt, 0);

    // 3: lw held by WB backpressure after its response
    ws_allowin = 1'b0;
    alloc(5'd4, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 64'h1004, 64'h8000_0000_0000_0000);
    check("lw_bypass_gated", byp_bus, 0);
    check("lw_hazard", hz_bus, {1'b1, 5'd4, 6'b0});
    resp(64'h8000_0000_0000_0000);
    check("lw_valid_held", ws_valid, 1);
    step();
    check("lw_still_held", cnt, 1);
    step();
    ws_allowin = 1'b1;
    step();
    check("lw_cnt_after", cnt, 0);

    // 4: fill with loads, then back-to-back responses
    r1 = 64'h1122_3344_8966_7788;
    r2 = 64'hBEEF_0000_0000_0000;
    alloc(5'd7, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h2003, r1);
    alloc(5'd9, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 64'h2006, r2);
    check("full_allowin", ms_allowin, 0);
    check("full_cnt", cnt, DEPTH);
    check("full_hazard", hz_bus, {1'b1, 5'd9, 1'b1, 5'd7});
    check("full_valid", ws_valid, 0);
    dok = 1'b1; rdata = r1;
    step();
    rdata = r2;
    step();
    dok = 1'b0;
    drain();

    // 5: full queue with done head: push and pop in one cycle
    ws_allowin = 1'b0;
    alloc(5'd10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'hAAAA, 64'h0);
    alloc(5'd11, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 64'hBBBB, 64'h0);
    check("full2_allowin", ms_allowin, 0);
    ws_allowin = 1'b1;
    alloc(5'd12, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'hCCCC, 64'h0);
    check("pushpop_cnt", cnt, DEPTH);
    drain();

    // 6: response latency to a waiting head load
    r1 = 64'hDEAD_BEEF_CAFE_F00D;
    alloc(5'd13, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 64'h3000, r1);
    check("ld_wait_valid", ws_valid, 0);
    dok = 1'b1; rdata = r1;
    #1;
    check("ld_ok_same_cycle", ws_valid, FWD);
    step();
    dok = 1'b0;
    #1;
    check("ld_ok_next_cycle", ws_valid, !FWD);
    drain();

    // 6b: spurious data_ok while empty changes nothing
    dok = 1'b1; rdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("spur_valid", ws_valid, 0);
    check("spur_allowin", ms_allowin, 1);
    step();
    dok = 1'b0;
    check("spur_cnt", cnt, 0);
    check("spur_bypass", byp_bus, 0);
    r2 = 64'h7654_3210_F00D_CAFE;
    alloc(5'd14, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 64'h4004, r2);
    step();
    check("spur_no_leak", ws_valid, 0);
    resp(r2);
    drain();

    step();
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
